// File: rtl/hps_ext_stream_if.sv
// Core-side stream bundle of hps_ext_stream.
//   tx_data  : core->HPS bytes, channel c at [8c+7:8c]
//   tx_wr    : per-channel push strobe
//   tx_full  : per-channel TX FIFO full (registered)
//   rx_data  : per-channel HPS->core head byte (show-ahead)
//   rx_valid : per-channel RX FIFO non-empty
//   rx_rd    : per-channel pop strobe
// master = core-side peripheral logic, slave = the bridge.
interface hps_ext_stream_if #(
  parameter int CHANNELS = 2
);
  logic [8*CHANNELS-1:0] tx_data;
  logic [CHANNELS-1:0]   tx_wr;
  logic [CHANNELS-1:0]   tx_full;
  logic [8*CHANNELS-1:0] rx_data;
  logic [CHANNELS-1:0]   rx_valid;
  logic [CHANNELS-1:0]   rx_rd;

  modport master (
    output tx_data, tx_wr, rx_rd,
    input  tx_full, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_wr, rx_rd,
    output tx_full, rx_data, rx_valid
  );
endinterface

// File: rtl/hps_ext_stream.sv
// Multi-channel byte-stream bridge between the HPS extension bus (io_enable
// side) and core-side peripherals. Each channel owns a TX FIFO (core->HPS)
// and an RX FIFO (HPS->core) of DEPTH entries with sticky overflow flags.
// Ports:
//   clk_sys  : system clock
//   reset_n  : asynchronous active-low reset
//   EXT_BUS  : [15:0] io_dout (out), [31:16] io_din, [32] io_dout_en (out),
//              [33] io_strobe, [34] io_enable, [35] unused
//   core     : core-side stream bundle (hps_ext_stream_if.slave)
// Command codes: channel c read = CMD_BASE+2c, write = CMD_BASE+2c+1.
module hps_ext_stream #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int CMD_BASE = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  inout  wire  [35:0]      EXT_BUS,
  hps_ext_stream_if.slave  core
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {PH_CMD, PH_STATUS, PH_DATA} phase_t;

  logic [15:0] io_din;
  logic        io_strobe;
  logic        io_enable;
  logic [15:0] io_dout;
  logic        io_dout_en;

  assign io_din    = EXT_BUS[31:16];
  assign io_strobe = EXT_BUS[33];
  assign io_enable = EXT_BUS[34];
  assign EXT_BUS[15:0] = io_dout;
  assign EXT_BUS[32]   = io_dout_en;

  wire unused_bus = &{1'b0, EXT_BUS[35], EXT_BUS[32], EXT_BUS[15:0]};

  // Occupancy reported in an 8-bit field, saturating at 255.
  function automatic logic [7:0] sat8(input logic [CW-1:0] n);
    logic [8:0] w;
    w = 9'(n);
    return (w > 9'd255) ? 8'hFF : w[7:0];
  endfunction

  function automatic logic [7:0] free8(input logic [CW-1:0] n);
    logic [8:0] w;
    w = 9'(DEPTH) - 9'(n);
    return w[7:0];
  endfunction

  // Transaction control
  phase_t         phase, phase_nxt;
  logic           cmd_ok, cmd_ok_nxt;
  logic           cmd_rd, cmd_rd_nxt;
  logic [CHW-1:0] cmd_ch, cmd_ch_nxt;
  logic [15:0]    dout_nxt;
  logic           dout_en_nxt;

  // FIFO state
  logic [7:0]    tx_mem [CHANNELS][DEPTH];
  logic [7:0]    rx_mem [CHANNELS][DEPTH];
  logic [PW-1:0] tx_wp  [CHANNELS];
  logic [PW-1:0] tx_rp  [CHANNELS];
  logic [PW-1:0] rx_wp  [CHANNELS];
  logic [PW-1:0] rx_rp  [CHANNELS];
  logic [CW-1:0] tx_cnt [CHANNELS];
  logic [CW-1:0] rx_cnt [CHANNELS];
  logic [CW-1:0] tx_cnt_nxt [CHANNELS];
  logic [CW-1:0] rx_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] tx_ovf, rx_ovf, tx_ovf_nxt, rx_ovf_nxt;
  logic [CHANNELS-1:0] tx_full_r;

  logic [CHANNELS-1:0] tx_push, tx_pop, tx_drop, tx_clr;
  logic [CHANNELS-1:0] rx_push, rx_pop, rx_drop;

  logic           cmd_hit, hit_rd;
  logic [CHW-1:0] hit_ch;
  logic           hps_data;

  // Full 16-bit command decode
  always_comb begin
    cmd_hit = 1'b0;
    hit_rd  = 1'b0;
    hit_ch  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (io_din == 16'(CMD_BASE + 2*c)) begin
        cmd_hit = 1'b1;
        hit_rd  = 1'b1;
        hit_ch  = CHW'(c);
      end
      if (io_din == 16'(CMD_BASE + 2*c + 1)) begin
        cmd_hit = 1'b1;
        hit_rd  = 1'b0;
        hit_ch  = CHW'(c);
      end
    end
  end

  assign hps_data = io_enable && io_strobe && (phase != PH_CMD) && cmd_ok;

  // Per-channel FIFO events. A full FIFO refuses a push even when a pop
  // happens on the same edge; the decision uses the registered count.
  always_comb begin
    tx_push = '0; tx_pop = '0; tx_drop = '0; tx_clr = '0;
    rx_push = '0; rx_pop = '0; rx_drop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tx_push[c] = core.tx_wr[c] && !tx_full_r[c];
      tx_drop[c] = core.tx_wr[c] &&  tx_full_r[c];
      tx_pop[c]  = hps_data && cmd_rd && (cmd_ch == CHW'(c)) &&
                   (phase == PH_DATA) && (tx_cnt[c] != '0);
      tx_clr[c]  = hps_data && cmd_rd && (cmd_ch == CHW'(c)) &&
                   (phase == PH_STATUS);
      rx_pop[c]  = core.rx_rd[c] && (rx_cnt[c] != '0);
      rx_push[c] = hps_data && !cmd_rd && (cmd_ch == CHW'(c)) &&
                   (rx_cnt[c] != CW'(DEPTH));
      rx_drop[c] = hps_data && !cmd_rd && (cmd_ch == CHW'(c)) &&
                   (rx_cnt[c] == CW'(DEPTH));

      tx_cnt_nxt[c] = tx_cnt[c] + CW'(tx_push[c]) - CW'(tx_pop[c]);
      rx_cnt_nxt[c] = rx_cnt[c] + CW'(rx_push[c]) - CW'(rx_pop[c]);
      // A new overflow wins over a simultaneous status-read clear.
      tx_ovf_nxt[c] = tx_drop[c] ? 1'b1 : (tx_clr[c] ? 1'b0 : tx_ovf[c]);
      rx_ovf_nxt[c] = rx_drop[c] ? 1'b1 : (rx_push[c] ? 1'b0 : rx_ovf[c]);
    end
  end

  // Bus transaction next state and response word
  always_comb begin
    phase_nxt   = phase;
    cmd_ok_nxt  = cmd_ok;
    cmd_rd_nxt  = cmd_rd;
    cmd_ch_nxt  = cmd_ch;
    dout_nxt    = io_dout;
    dout_en_nxt = io_dout_en;
    if (!io_enable) begin
      phase_nxt   = PH_CMD;
      dout_nxt    = 16'h0000;
      dout_en_nxt = 1'b0;
    end else if (io_strobe) begin
      if (phase == PH_CMD) begin
        cmd_ok_nxt  = cmd_hit;
        cmd_rd_nxt  = hit_rd;
        cmd_ch_nxt  = hit_ch;
        dout_en_nxt = cmd_hit;
        dout_nxt    = 16'h0000;
        phase_nxt   = PH_STATUS;
      end else begin
        phase_nxt = PH_DATA;
        if (cmd_ok) begin
          if (cmd_rd) begin
            if (phase == PH_STATUS)
              dout_nxt = {sat8(tx_cnt[cmd_ch]), 4'hA, 2'b00, tx_ovf[cmd_ch],
                          (tx_cnt[cmd_ch] != '0)};
            else if (tx_cnt[cmd_ch] != '0)
              dout_nxt = {7'b0, 1'b1, tx_mem[cmd_ch][tx_rp[cmd_ch]]};
            else
              dout_nxt = 16'h0000;
          end else begin
            // Free slots account for a core pop on the same edge.
            dout_nxt = {rx_ovf_nxt[cmd_ch], 7'b0, free8(rx_cnt_nxt[cmd_ch])};
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= PH_CMD;
      cmd_ok     <= 1'b0;
      cmd_rd     <= 1'b0;
      cmd_ch     <= '0;
      io_dout    <= 16'h0000;
      io_dout_en <= 1'b0;
      tx_ovf     <= '0;
      rx_ovf     <= '0;
      tx_full_r  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        tx_wp[c]  <= '0;
        tx_rp[c]  <= '0;
        rx_wp[c]  <= '0;
        rx_rp[c]  <= '0;
        tx_cnt[c] <= '0;
        rx_cnt[c] <= '0;
      end
    end else begin
      phase      <= phase_nxt;
      cmd_ok     <= cmd_ok_nxt;
      cmd_rd     <= cmd_rd_nxt;
      cmd_ch     <= cmd_ch_nxt;
      io_dout    <= dout_nxt;
      io_dout_en <= dout_en_nxt;
      tx_ovf     <= tx_ovf_nxt;
      rx_ovf     <= rx_ovf_nxt;
      for (int c = 0; c < CHANNELS; c++) begin
        tx_full_r[c] <= (tx_cnt_nxt[c] == CW'(DEPTH));
        tx_cnt[c]    <= tx_cnt_nxt[c];
        rx_cnt[c]    <= rx_cnt_nxt[c];
        // Pointers wrap naturally because DEPTH is a power of two.
        if (tx_push[c]) tx_wp[c] <= tx_wp[c] + PW'(1);
        if (tx_pop[c])  tx_rp[c] <= tx_rp[c] + PW'(1);
        if (rx_push[c]) rx_wp[c] <= rx_wp[c] + PW'(1);
        if (rx_pop[c])  rx_rp[c] <= rx_rp[c] + PW'(1);
      end
    end
  end

  // FIFO storage carries no reset; validity comes from the counts.
  always_ff @(posedge clk_sys) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (tx_push[c]) tx_mem[c][tx_wp[c]] <= core.tx_data[8*c +: 8];
      if (rx_push[c]) rx_mem[c][rx_wp[c]] <= io_din[7:0];
    end
  end

  // Head byte is masked to zero while empty so nothing stale leaks out.
  always_comb begin
    core.rx_data  = '0;
    core.rx_valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      core.rx_valid[c]       = (rx_cnt[c] != '0);
      core.rx_data[8*c +: 8] = (rx_cnt[c] != '0) ? rx_mem[c][rx_rp[c]] : 8'h00;
    end
  end

  assign core.tx_full = tx_full_r;

endmodule

// File: tb/tb_hps_ext_stream.sv
module tb_hps_ext_stream;
  localparam int CH       = 2;
  localparam int DEPTH    = 8;
  localparam int CMD_BASE = 4;
  localparam int TDW      = 8 * CH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] io_din = 16'h0000;
  logic        io_strobe = 1'b0;
  logic        io_enable = 1'b0;
  wire  [35:0] ext_bus;

  assign ext_bus[31:16] = io_din;
  assign ext_bus[33]    = io_strobe;
  assign ext_bus[34]    = io_enable;
  assign ext_bus[35]    = 1'b0;

  hps_ext_stream_if #(.CHANNELS(CH)) core_if();

  hps_ext_stream #(.CHANNELS(CH), .DEPTH(DEPTH), .CMD_BASE(CMD_BASE)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .EXT_BUS (ext_bus),
    .core    (core_if)
  );

  int checks = 0;
  int errors = 0;
  bit rand_core = 1'b0;

  // Reference model: queues per FIFO plus the bus transaction view.
  logic [7:0]  q_tx [CH][$];
  logic [7:0]  q_rx [CH][$];
  bit          m_tx_ovf [CH];
  bit          m_rx_ovf [CH];
  int          m_phase;
  bit          m_ok, m_rd;
  int          m_ch;
  logic [15:0] m_dout;
  bit          m_den;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ok = 0; m_rd = 0; m_ch = 0; m_dout = 16'h0; m_den = 0;
    for (int c = 0; c < CH; c++) begin
      q_tx[c].delete();
      q_rx[c].delete();
      m_tx_ovf[c] = 0;
      m_rx_ovf[c] = 0;
    end
  endtask

  // Applies the effect of the coming clock edge with the current inputs.
  task automatic model_edge();
    int pre_tx [CH];
    int pre_rx [CH];
    bit hps_pop, hps_stat, hps_wr;
    int sat;
    hps_pop = 0; hps_stat = 0; hps_wr = 0;
    for (int c = 0; c < CH; c++) begin
      pre_tx[c] = q_tx[c].size();
      pre_rx[c] = q_rx[c].size();
    end
    if (!io_enable) begin
      m_phase = 0; m_dout = 16'h0; m_den = 0;
    end else if (io_strobe) begin
      if (m_phase == 0) begin
        m_ok = 0;
        for (int c = 0; c < CH; c++) begin
          if (io_din == 16'(CMD_BASE + 2*c))     begin m_ok = 1; m_rd = 1; m_ch = c; end
          if (io_din == 16'(CMD_BASE + 2*c + 1)) begin m_ok = 1; m_rd = 0; m_ch = c; end
        end
        m_den = m_ok;
        m_dout = 16'h0;
        m_phase = 1;
      end else begin
        if (m_ok && m_rd && m_phase == 1) begin
          sat = (pre_tx[m_ch] > 255) ? 255 : pre_tx[m_ch];
          m_dout = {8'(sat), 4'hA, 2'b00, m_tx_ovf[m_ch], (pre_tx[m_ch] > 0)};
          hps_stat = 1;
        end else if (m_ok && m_rd) begin
          if (pre_tx[m_ch] > 0) begin
            m_dout = {8'h01, q_tx[m_ch][0]};
            hps_pop = 1;
          end else m_dout = 16'h0;
        end else if (m_ok) begin
          hps_wr = 1;
        end
        m_phase = 2;
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (hps_pop && m_ch == c) void'(q_tx[c].pop_front());
      if (hps_stat && m_ch == c) m_tx_ovf[c] = 0;
      if (core_if.tx_wr[c]) begin
        if (pre_tx[c] < DEPTH) q_tx[c].push_back(core_if.tx_data[8*c +: 8]);
        else m_tx_ovf[c] = 1;
      end
      if (core_if.rx_rd[c] && pre_rx[c] > 0) void'(q_rx[c].pop_front());
      if (hps_wr && m_ch == c) begin
        if (pre_rx[c] < DEPTH) begin
          q_rx[c].push_back(io_din[7:0]);
          m_rx_ovf[c] = 0;
        end else m_rx_ovf[c] = 1;
        m_dout = {m_rx_ovf[c], 7'b0, 8'(DEPTH - q_rx[c].size())};
      end
    end
  endtask

  task automatic compare_all();
    chk("io_dout", ext_bus[15:0], m_dout);
    chk("io_dout_en", 16'(ext_bus[32]), 16'(m_den));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("tx_full[%0d]", c), 16'(core_if.tx_full[c]), 16'(q_tx[c].size() == DEPTH));
      chk($sformatf("rx_valid[%0d]", c), 16'(core_if.rx_valid[c]), 16'(q_rx[c].size() > 0));
      chk($sformatf("rx_data[%0d]", c), 16'(core_if.rx_data[8*c +: 8]),
          16'((q_rx[c].size() > 0) ? q_rx[c][0] : 8'h00));
    end
  endtask

  task automatic step();
    if (rand_core) begin
      for (int c = 0; c < CH; c++) begin
        core_if.tx_wr[c] = ($urandom_range(0, 2) == 0);
        core_if.rx_rd[c] = ($urandom_range(0, 2) == 0);
      end
      core_if.tx_data = TDW'($urandom);
    end
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic hps_cmd(input logic [15:0] cmd);
    io_enable = 1'b1; io_strobe = 1'b1; io_din = cmd;
    step();
    io_strobe = 1'b0;
  endtask

  task automatic hps_word(input logic [15:0] d);
    io_strobe = 1'b1; io_din = d;
    step();
    io_strobe = 1'b0;
  endtask

  task automatic hps_end();
    io_enable = 1'b0; io_strobe = 1'b0;
    step();
  endtask

  task automatic core_push(input int c, input logic [7:0] b);
    core_if.tx_wr = '0;
    core_if.tx_wr[c] = 1'b1;
    core_if.tx_data[8*c +: 8] = b;
    step();
    core_if.tx_wr = '0;
  endtask

  task automatic core_pop(input int c);
    core_if.rx_rd = '0;
    core_if.rx_rd[c] = 1'b1;
    step();
    core_if.rx_rd = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cmd;
    int nw, sel;
    core_if.tx_data = '0;
    core_if.tx_wr   = '0;
    core_if.rx_rd   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", ext_bus[15:0], 16'h0000);
    chk("reset_den", 16'(ext_bus[32]), 16'h0000);
    chk("reset_rx_valid", 16'(core_if.rx_valid), 16'h0000);
    chk("reset_tx_full", 16'(core_if.tx_full), 16'h0000);
    compare_all();
    reset_n = 1'b1;
    step();

    // Empty status
    hps_cmd(16'h0004);
    chk("empty_den", 16'(ext_bus[32]), 16'h0001);
    hps_word(16'h0000);
    chk("empty_status", ext_bus[15:0], 16'h00A0);
    hps_end();

    // TX path, channel 1
    core_push(1, 8'h11); core_push(1, 8'h22); core_push(1, 8'h33);
    hps_cmd(16'h0006);
    hps_word(16'h0000); chk("tx1_status", ext_bus[15:0], 16'h03A1);
    hps_word(16'h0000); chk("tx1_b0", ext_bus[15:0], 16'h0111);
    hps_word(16'h0000); chk("tx1_b1", ext_bus[15:0], 16'h0122);
    hps_word(16'h0000); chk("tx1_b2", ext_bus[15:0], 16'h0133);
    hps_word(16'h0000); chk("tx1_empty", ext_bus[15:0], 16'h0000);
    hps_end();

    // RX overflow, channel 0
    hps_cmd(16'h0005);
    for (int i = 0; i < 9; i++) begin
      hps_word(16'(i + 1));
      chk("rx_ovf_resp", ext_bus[15:0], (i < 8) ? 16'(7 - i) : 16'h8000);
    end
    hps_end();
    for (int i = 0; i < 8; i++) begin
      chk("rx_pop_data", 16'(core_if.rx_data[7:0]), 16'(i + 1));
      core_pop(0);
    end
    chk("rx_drained", 16'(core_if.rx_valid[0]), 16'h0000);

    // TX overflow and clear, channel 0
    for (int i = 0; i < 9; i++) begin
      core_if.tx_wr = 2'b01;
      core_if.tx_data[7:0] = 8'(8'hA0 + i);
      step();
      chk("tx_full_fill", 16'(core_if.tx_full[0]), (i >= 7) ? 16'h0001 : 16'h0000);
    end
    core_if.tx_wr = '0;
    hps_cmd(16'h0004); hps_word(16'h0000);
    chk("tx_ovf_status", ext_bus[15:0], 16'h08A3);
    hps_end();
    hps_cmd(16'h0004); hps_word(16'h0000);
    chk("tx_ovf_cleared", ext_bus[15:0], 16'h08A1);
    for (int i = 0; i < 8; i++) begin
      hps_word(16'h0000);
      chk("tx_drain", ext_bus[15:0], 16'(16'h01A0 + i));
    end
    hps_end();

    // Simultaneous RX push and core pop
    hps_cmd(16'h0005);
    hps_word(16'h0055); hps_word(16'h0066);
    core_if.rx_rd = 2'b01;
    hps_word(16'h0077);
    core_if.rx_rd = '0;
    chk("simul_rx_free", ext_bus[15:0], 16'h0006);
    chk("simul_rx_head", 16'(core_if.rx_data[7:0]), 16'h0066);
    hps_end();
    core_pop(0);
    chk("simul_rx_tail", 16'(core_if.rx_data[7:0]), 16'h0077);
    core_pop(0);

    // Simultaneous TX pop and core push, channel 1
    core_push(1, 8'hA1); core_push(1, 8'hA2);
    hps_cmd(16'h0006); hps_word(16'h0000);
    chk("simul_tx_status", ext_bus[15:0], 16'h02A1);
    core_if.tx_wr = 2'b10; core_if.tx_data[15:8] = 8'hA3;
    hps_word(16'h0000);
    core_if.tx_wr = '0;
    chk("simul_tx_b0", ext_bus[15:0], 16'h01A1);
    hps_word(16'h0000); chk("simul_tx_b1", ext_bus[15:0], 16'h01A2);
    hps_word(16'h0000); chk("simul_tx_b2", ext_bus[15:0], 16'h01A3);
    hps_word(16'h0000); chk("simul_tx_end", ext_bus[15:0], 16'h0000);
    hps_end();

    // Framing: abort after status, then unknown command
    core_push(0, 8'h5A);
    hps_cmd(16'h0004); hps_word(16'h0000);
    chk("abort_status", ext_bus[15:0], 16'h01A1);
    hps_end();
    chk("abort_den", 16'(ext_bus[32]), 16'h0000);
    hps_cmd(16'h0004); hps_word(16'h0000);
    chk("abort_nopop", ext_bus[15:0], 16'h01A1);
    hps_word(16'h0000);
    chk("abort_byte", ext_bus[15:0], 16'h015A);
    hps_end();
    hps_cmd(16'h0003);
    chk("unknown_den", 16'(ext_bus[32]), 16'h0000);
    hps_word(16'h1234);
    chk("unknown_dout", ext_bus[15:0], 16'h0000);
    hps_end();

    // Asynchronous reset mid-operation
    core_push(1, 8'hC1); core_push(1, 8'hC2);
    hps_cmd(16'h0005); hps_word(16'h00EE);
    #2;
    reset_n = 1'b0;
    io_enable = 1'b0; io_strobe = 1'b0;
    model_reset();
    #1;
    chk("areset_dout", ext_bus[15:0], 16'h0000);
    chk("areset_den", 16'(ext_bus[32]), 16'h0000);
    chk("areset_tx_full", 16'(core_if.tx_full), 16'h0000);
    chk("areset_rx_valid", 16'(core_if.rx_valid), 16'h0000);
    chk("areset_rx_data", core_if.rx_data, 16'h0000);
    #2;
    reset_n = 1'b1;
    hps_cmd(16'h0006); hps_word(16'h0000);
    chk("areset_status", ext_bus[15:0], 16'h00A0);
    hps_end();

    // Randomized traffic against the model
    rand_core = 1'b1;
    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        case ($urandom_range(0, 2))
          0: cmd = 16'h0003;
          1: cmd = 16'(CMD_BASE + 2*CH);
          default: cmd = 16'($urandom_range(16'h0100, 16'hFFFF));
        endcase
      end else begin
        cmd = 16'(CMD_BASE + 2*int'($urandom_range(0, CH - 1)) + int'($urandom_range(0, 1)));
      end
      hps_cmd(cmd);
      nw = int'($urandom_range(0, 12));
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) step();
        hps_word(16'($urandom));
      end
      hps_end();
      repeat ($urandom_range(0, 2)) step();
    end
    rand_core = 1'b0;
    core_if.tx_wr = '0;
    core_if.rx_rd = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
